ram_fifo_rv: RTL and testbench

//  Ready/valid RAM FIFO on distributed-RAM storage, successor to the basic RAM FIFO. Adds a

---
 rtl/ram_fifo_rv_if.sv | 35 +++
 rtl/ram_fifo_rv.sv | 103 ++++++++++
 tb/tb_ram_fifo_rv.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_rv_if.sv
// rtl/ram_fifo_rv_if.sv - handshake and status bundle for ram_fifo_rv
// Purpose: groups the write/read streams, control inputs and status outputs.
// Ports (master drives i_*, slave drives o_*):
//   i_fifoen, i_flush            control
//   i_wr_valid, i_wrdata         write stream in, o_wr_ready back
//   o_rd_valid, o_rddata         read stream out, i_rd_ready back
//   o_count, o_almost_full, o_almost_empty  occupancy status
interface ram_fifo_rv_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              i_fifoen;
  logic              i_flush;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wrdata;
  logic              o_wr_ready;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rddata;
  logic              i_rd_ready;
  logic [CW-1:0]     o_count;
  logic              o_almost_full;
  logic              o_almost_empty;

  modport master (
    output i_fifoen, i_flush, i_wr_valid, i_wrdata, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rddata, o_count, o_almost_full, o_almost_empty
  );

  modport slave (
    input  i_fifoen, i_flush, i_wr_valid, i_wrdata, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rddata, o_count, o_almost_full, o_almost_empty
  );
endinterface

// File: rtl/ram_fifo_rv.sv
// rtl/ram_fifo_rv.sv - ready/valid RAM FIFO with FWFT output register and bypass
// Purpose: same-clock FIFO; storage is a registered head word plus a
//   distributed RAM. Writes into an empty RAM go straight to the head register.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   f     ram_fifo_rv_if.slave (streams, enable/flush, count and flags)
module ram_fifo_rv #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         rstn,
  ram_fifo_rv_if.slave f
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrptr;
  logic [PW-1:0]     rdptr;
  logic [CW-1:0]     count;
  logic              out_vld_rg;
  logic [DATA_W-1:0] out_data_rg;

  logic full;
  logic wr_ready;
  logic wr_hs;
  logic rd_hs;
  logic ram_empty;
  logic load;
  logic bypass;
  logic ram_wr;
  logic ram_rd;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign wr_ready = f.i_fifoen & ~full;
  assign wr_hs    = f.i_wr_valid & wr_ready;
  assign rd_hs    = f.i_fifoen & out_vld_rg & f.i_rd_ready;

  // RAM holds count-1 words while the head register is valid, none otherwise.
  assign ram_empty = ~out_vld_rg | (count == CW'(1));
  assign load      = ~out_vld_rg | rd_hs;
  assign ram_rd    = load & ~ram_empty;
  assign bypass    = load & ram_empty & wr_hs;
  assign ram_wr    = wr_hs & ~bypass;

  assign f.o_wr_ready     = wr_ready;
  assign f.o_rd_valid     = f.i_fifoen & out_vld_rg;
  assign f.o_rddata       = out_data_rg;
  assign f.o_count        = count;
  assign f.o_almost_full  = (count >= CW'(AF_LVL));
  assign f.o_almost_empty = (count <= CW'(AE_LVL));

  // Storage array has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (ram_wr && !f.i_flush) begin
      mem[wrptr] <= f.i_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrptr       <= '0;
      rdptr       <= '0;
      count       <= '0;
      out_vld_rg  <= 1'b0;
      out_data_rg <= '0;
    end else if (f.i_fifoen) begin
      if (f.i_flush) begin
        wrptr      <= '0;
        rdptr      <= '0;
        count      <= '0;
        out_vld_rg <= 1'b0;
      end else begin
        if (ram_wr) begin
          wrptr <= nxt_ptr(wrptr);
        end
        if (ram_rd) begin
          out_data_rg <= mem[rdptr];
          out_vld_rg  <= 1'b1;
          rdptr       <= nxt_ptr(rdptr);
        end else if (bypass) begin
          out_data_rg <= f.i_wrdata;
          out_vld_rg  <= 1'b1;
        end else if (rd_hs) begin
          out_vld_rg <= 1'b0;
        end
        case ({wr_hs, rd_hs})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ram_fifo_rv.sv
// tb/tb_ram_fifo_rv.sv - scoreboard bench for ram_fifo_rv (DEPTH 8 and DEPTH 5 in parallel)
module tb_ram_fifo_rv;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fifoen = 1'b1;
  logic       flush = 1'b0;
  logic       wv = 1'b0;
  logic [7:0] wd = 8'h00;
  logic       rr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  always #5 clk = ~clk;

  ram_fifo_rv_if #(.DATA_W(8), .DEPTH(8)) a ();
  ram_fifo_rv_if #(.DATA_W(8), .DEPTH(5)) b ();

  assign a.i_fifoen = fifoen;
  assign a.i_flush = flush;
  assign a.i_wr_valid = wv;
  assign a.i_wrdata = wd;
  assign a.i_rd_ready = rr;
  assign b.i_fifoen = fifoen;
  assign b.i_flush = flush;
  assign b.i_wr_valid = wv;
  assign b.i_wrdata = wd;
  assign b.i_rd_ready = rr;

  ram_fifo_rv #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) dut8 (
    .clk(clk), .rstn(rstn), .f(a.slave)
  );
  ram_fifo_rv #(.DATA_W(8), .DEPTH(5), .AF_LVL(4), .AE_LVL(1)) dut5 (
    .clk(clk), .rstn(rstn), .f(b.slave)
  );

  logic [1:0] wr_rdy, rd_vld, afl, ael;
  logic [7:0] rdat [2];
  logic [3:0] cntv [2];
  assign wr_rdy = {b.o_wr_ready, a.o_wr_ready};
  assign rd_vld = {b.o_rd_valid, a.o_rd_valid};
  assign afl = {b.o_almost_full, a.o_almost_full};
  assign ael = {b.o_almost_empty, a.o_almost_empty};
  assign rdat[0] = a.o_rddata;
  assign rdat[1] = b.o_rddata;
  assign cntv[0] = a.o_count;
  assign cntv[1] = {1'b0, b.o_count};

  function automatic int cap(input int k);
    return (k == 0) ? 8 : 5;
  endfunction
  function automatic int af_lvl(input int k);
    return (k == 0) ? 6 : 4;
  endfunction
  function automatic int ae_lvl(input int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic int sz(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction
  function automatic logic [7:0] front(input int k);
    return (k == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic sb_push(input int k, input logic [7:0] d);
    if (k == 0) sb0.push_back(d);
    else sb1.push_back(d);
  endtask
  task automatic sb_pop(input int k);
    if (k == 0) void'(sb0.pop_front());
    else void'(sb1.pop_front());
  endtask
  task automatic sb_clear(input int k);
    if (k == 0) sb0.delete();
    else sb1.delete();
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, (k == 0) ? 8 : 5, obs, exp);
    end
  endtask

  // Outputs after an edge: count, flags, valid and head-of-queue data.
  task automatic post_checks(input logic after_reset);
    for (int k = 0; k < 2; k++) begin
      chk("count", k, 32'(cntv[k]), 32'(sz(k)));
      chk("almost_full", k, 32'(afl[k]), 32'(sz(k) >= af_lvl(k)));
      chk("almost_empty", k, 32'(ael[k]), 32'(sz(k) <= ae_lvl(k)));
      chk("rd_valid", k, 32'(rd_vld[k]), 32'(fifoen && sz(k) > 0));
      chk("wr_ready", k, 32'(wr_rdy[k]), 32'(fifoen && sz(k) < cap(k)));
      if (after_reset) chk("rddata_rst", k, 32'(rdat[k]), 32'h0);
      else if (sz(k) > 0) chk("head", k, 32'(rdat[k]), 32'(front(k)));
    end
  endtask

  // One clock: drive at negedge, predict handshakes from the model, step, check.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    logic wh, rh;
    logic was_rst;
    wv = v; wd = d; rr = r;
    #1;
    was_rst = !rstn;
    for (int k = 0; k < 2; k++) begin
      chk("wr_ready_pre", k, 32'(wr_rdy[k]), 32'(fifoen && sz(k) < cap(k)));
      wh = fifoen && v && (sz(k) < cap(k));
      rh = fifoen && r && (sz(k) > 0);
      if (!rstn || (fifoen && flush)) begin
        sb_clear(k);
      end else begin
        if (rh) begin
          chk("pop_data", k, 32'(rdat[k]), 32'(front(k)));
          sb_pop(k);
        end
        if (wh) sb_push(k, d);
      end
    end
    @(posedge clk);
    @(negedge clk);
    post_checks(was_rst);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    post_checks(1'b1);
    chk("almost_empty_rst", 0, 32'(ael[0]), 32'h1);
    rstn = 1'b1;

    // 1: single write then read
    cyc(1'b1, 8'hA5, 1'b0);
    chk("latency_data", 0, 32'(rdat[0]), 32'hA5);
    chk("latency_valid", 1, 32'(rd_vld[1]), 32'h1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_after_read", 0, 32'(cntv[0]), 32'h0);

    // 2: fill without reads, then read back in order
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("full_ready", 0, 32'(wr_rdy[0]), 32'h0);
    chk("full_af", 0, 32'(afl[0]), 32'h1);
    drain();

    // 3: random gaps, several pointer wraps on the 5-deep FIFO
    for (int i = 0; i < 80; i++)
      cyc(($urandom_range(0, 3) != 0), 8'(8'h40 + i), ($urandom_range(0, 1) == 1));
    drain();

    // 4: bypass at count 1 with simultaneous read and write
    cyc(1'b1, 8'h99, 1'b0);
    cyc(1'b1, 8'h3C, 1'b1);
    chk("bypass_data", 0, 32'(rdat[0]), 32'h3C);
    chk("bypass_count", 1, 32'(cntv[1]), 32'h1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    cyc(1'b1, 8'hEF, 1'b0);
    drain();

    // 5: flush at count 4 with a concurrent write
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    flush = 1'b1;
    cyc(1'b1, 8'h77, 1'b1);
    flush = 1'b0;
    chk("flush_count", 0, 32'(cntv[0]), 32'h0);
    chk("flush_valid", 1, 32'(rd_vld[1]), 32'h0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // 6: enable low freezes state; reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    fifoen = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hAA, 1'b1);
    fifoen = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("frozen_count", 0, 32'(cntv[0]), 32'h3);
    rstn = 1'b0;
    cyc(1'b1, 8'h66, 1'b1);
    rstn = 1'b1;
    chk("rst_ae", 1, 32'(ael[1]), 32'h1);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
